// File: rtl/alu_add_sequencer.sv
// Operand/opcode front end and result stage for an external ripple-carry adder.
// Define ALU_SAT_EN to clamp signed-overflowing ADD/ADC/SUB/SBC results to 0x7F/0x80.
module alu_add_sequencer #(
    parameter int WIDTH       = 8,
    parameter bit CARRY_RESET = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_c,
    output logic             out_z,
    output logic             out_n,
    output logic             out_v
);
    // state | meaning
    // IDLE  | waiting for an op, in_ready=1
    // EXEC  | adder settling from registered operands
    // DONE  | result presented, out_valid=1
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_INC = 3'b100;
    localparam logic [2:0] OP_DEC = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_CLC = 3'b111;
    localparam int MSB = WIDTH - 1;

    state_t state, nextState;
    logic inReady, acceptOp;
    logic [2:0] opReg;
    logic carryFlag;
    logic [WIDTH-1:0] nextA, nextB;
    logic nextCin;
    logic [WIDTH-1:0] capResult, flagSrc;
    logic capC, capV, rawV;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        inReady   = 1'b0;
        case (state)
            IDLE: begin
                inReady = 1'b1;
                if (in_valid) nextState = EXEC;
            end
            EXEC: nextState = DONE;
            DONE: begin
                // Holding in DONE ignores in_valid so the presented result stays put.
                if (out_ready) begin
                    inReady   = 1'b1;
                    nextState = in_valid ? EXEC : IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign in_ready  = inReady;
    assign acceptOp  = in_valid & inReady;
    assign out_valid = (state == DONE);

    always_comb begin
        nextA   = in_a;
        nextB   = in_b;
        nextCin = 1'b0;
        case (in_op)
            OP_ADD: nextCin = 1'b0;
            OP_ADC: nextCin = carryFlag;
            OP_SUB, OP_CMP: begin
                nextB   = ~in_b;
                nextCin = 1'b1;
            end
            OP_SBC: begin
                nextB   = ~in_b;
                nextCin = carryFlag;
            end
            OP_INC: begin
                nextB   = '0;
                nextCin = 1'b1;
            end
            OP_DEC: nextB = '1;
            OP_CLC: begin
                // CLC never reaches the adder; operand registers keep their value.
                nextA   = add_a;
                nextB   = add_b;
                nextCin = add_cin;
            end
            default: nextCin = 1'b0;
        endcase
    end

    assign rawV = (add_a[MSB] == add_b[MSB]) && (add_sum[MSB] != add_a[MSB]);

    always_comb begin
        capResult = add_sum;
        flagSrc   = add_sum;
        capC      = add_cout;
        capV      = rawV;
        case (opReg)
            OP_CLC: begin
                capResult = '0;
                flagSrc   = '0;
                capC      = 1'b0;
                capV      = 1'b0;
            end
            OP_INC, OP_DEC: capV = 1'b0;
            OP_CMP: capResult = add_a;
            default: begin
`ifdef ALU_SAT_EN
                if (rawV) begin
                    capResult = add_sum[MSB] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
                    flagSrc   = capResult;
                end
`else
                capResult = add_sum;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a      <= '0;
            add_b      <= '0;
            add_cin    <= 1'b0;
            opReg      <= OP_ADD;
            out_result <= '0;
            out_c      <= 1'b0;
            out_z      <= 1'b0;
            out_n      <= 1'b0;
            out_v      <= 1'b0;
            carryFlag  <= CARRY_RESET;
        end else begin
            if (acceptOp) begin
                opReg   <= in_op;
                add_a   <= nextA;
                add_b   <= nextB;
                add_cin <= nextCin;
            end
            if (state == EXEC) begin
                out_result <= capResult;
                out_c      <= capC;
                out_z      <= (flagSrc == '0);
                out_n      <= flagSrc[MSB];
                out_v      <= capV;
                carryFlag  <= capC;
            end
        end
    end
endmodule

// File: tb/tb_alu_add_sequencer.sv
// Bench for alu_add_sequencer: directed literal cases plus randomized traffic
// checked every cycle against an arithmetic model of the add-class ops.
module tb_alu_add_sequencer;
    localparam int WIDTH = 8;
    localparam bit CARRY_RESET = 1'b0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [2:0] in_op = 3'd0;
    logic [7:0] in_a = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic [7:0] add_a, add_b, add_sum;
    logic add_cin, add_cout;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [7:0] out_result;
    logic out_c, out_z, out_n, out_v;

    alu_add_sequencer #(.WIDTH(WIDTH), .CARRY_RESET(CARRY_RESET)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_c(out_c), .out_z(out_z), .out_n(out_n), .out_v(out_v)
    );

    always #5 clk = ~clk;

    // external ripple-carry adder
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    typedef struct {
        logic [2:0] op;
        logic [7:0] res;
        logic [3:0] flags;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ecin;
        int         due;
    } exp_t;

    exp_t q[$];
    bit modelC = CARRY_RESET;
    int cyc = 0;
    int nChecks = 0;
    int nFails = 0;
    bit expValid, expReady;
    exp_t e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input bit cin, input int due);
        exp_t r;
        int ua, ub, sa, sb, full, sfull, bor;
        bit c, v;
        logic [7:0] fv;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        bor = cin ? 0 : 1;
        full = 0; sfull = 0; c = 1'b0; v = 1'b0;
        r.op = op; r.ea = a; r.eb = b; r.ecin = 1'b0; r.due = due;
        case (op)
            3'd0: begin full = ua + ub; sfull = sa + sb; c = full > 255; end
            3'd1: begin full = ua + ub + int'(cin); sfull = sa + sb + int'(cin); c = full > 255; r.ecin = cin; end
            3'd2, 3'd6: begin full = ua - ub; sfull = sa - sb; c = full >= 0; r.eb = ~b; r.ecin = 1'b1; end
            3'd3: begin full = ua - ub - bor; sfull = sa - sb - bor; c = full >= 0; r.eb = ~b; r.ecin = cin; end
            3'd4: begin full = ua + 1; c = full > 255; r.eb = 8'h00; r.ecin = 1'b1; end
            3'd5: begin full = ua - 1; c = full >= 0; r.eb = 8'hFF; end
            default: begin full = 0; c = 1'b0; end
        endcase
        if (op <= 3'd3 || op == 3'd6) v = (sfull > 127) || (sfull < -128);
        fv = 8'(full);
        r.res = (op == 3'd6) ? a : fv;
`ifdef ALU_SAT_EN
        if (op <= 3'd3 && v) begin
            fv = (sfull > 127) ? 8'h7F : 8'h80;
            r.res = fv;
        end
`endif
        r.flags = {c, fv == 8'h00, fv[7], v};
        return r;
    endfunction

    // per-cycle comparison against the model; inputs are stable at the falling edge
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_result", 32'(out_result), 32'd0);
            check("rst_flags", 32'({out_c, out_z, out_n, out_v}), 32'd0);
            check("rst_add_regs", 32'({add_a, add_b, add_cin}), 32'd0);
            q.delete();
            modelC = CARRY_RESET;
        end else begin
            expValid = (q.size() > 0) && (cyc >= q[0].due);
            expReady = (q.size() == 0) || (expValid && out_ready);
            check("in_ready", 32'(in_ready), 32'(expReady));
            check("out_valid", 32'(out_valid), 32'(expValid));
            if (q.size() > 0 && cyc == q[0].due - 1 && q[0].op != 3'd7)
                check("operands", 32'({add_a, add_b, add_cin}), 32'({q[0].ea, q[0].eb, q[0].ecin}));
            if (expValid) begin
                check("out_result", 32'(out_result), 32'(q[0].res));
                check("flags_CZNV", 32'({out_c, out_z, out_n, out_v}), 32'(q[0].flags));
            end
            if (expValid && out_ready) void'(q.pop_front());
            if (in_valid && expReady) begin
                e = model(in_op, in_a, in_b, modelC, cyc + 2);
                modelC = e.flags[3];
                q.push_back(e);
            end
        end
    end

    task automatic sendOp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int k;
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output logic [7:0] r, output logic [3:0] f, output int waited);
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("result_timeout", 32'(out_valid), 32'd1);
        r = out_result;
        f = {out_c, out_z, out_n, out_v};
    endtask

    task automatic runOp(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] expR, input logic [3:0] expF);
        logic [7:0] r;
        logic [3:0] f;
        int w;
        sendOp(op, a, b);
        waitResult(r, f, w);
        check({name, "_result"}, 32'(r), 32'(expR));
        check({name, "_flags"}, 32'(f), 32'(expF));
        check({name, "_latency"}, 32'(w), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] r;
        logic [3:0] f;
        int w;

        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef ALU_SAT_EN
        runOp("add_7f_01", 3'd0, 8'h7F, 8'h01, 8'h7F, 4'b0001);
`else
        runOp("add_7f_01", 3'd0, 8'h7F, 8'h01, 8'h80, 4'b0011);
`endif
        runOp("sub_05_05", 3'd2, 8'h05, 8'h05, 8'h00, 4'b1100);
        runOp("cmp_03_05", 3'd6, 8'h03, 8'h05, 8'h03, 4'b0010);
        runOp("add_ff_01", 3'd0, 8'hFF, 8'h01, 8'h00, 4'b1100);
        runOp("adc_carry", 3'd1, 8'h00, 8'h00, 8'h01, 4'b0000);
        runOp("dec_00", 3'd5, 8'h00, 8'h00, 8'hFF, 4'b0010);
        runOp("clc", 3'd7, 8'h12, 8'h34, 8'h00, 4'b0100);
        runOp("adc_after_clc", 3'd1, 8'h00, 8'h00, 8'h00, 4'b0100);

        // stall in DONE; a pulsed request must not be taken
        out_ready = 1'b0;
        sendOp(3'd0, 8'h10, 8'h20);
        waitResult(r, f, w);
        check("stall_result", 32'(r), 32'h30);
        in_op = 3'd4; in_a = 8'h55;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_hold", 32'({out_result, out_c, out_z, out_n, out_v}), 32'({8'h30, 4'b0000}));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release_idle", 32'(out_valid), 32'd0);

        // back-to-back accept in DONE
        sendOp(3'd0, 8'h01, 8'h01);
        waitResult(r, f, w);
        in_op = 3'd4; in_a = 8'hFF; in_b = 8'h00; in_valid = 1'b1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        waitResult(r, f, w);
        check("b2b_inc_result", 32'({r, f}), 32'({8'h00, 4'b1100}));
        check("b2b_latency", 32'(w), 32'd1);
        @(posedge clk); #1;

        // reset while an op is in EXEC
        runOp("pre_rst_carry", 3'd0, 8'hFF, 8'h01, 8'h00, 4'b1100);
        sendOp(3'd0, 8'h7F, 8'h7F);
        rst_n = 1'b0;
        #1;
        check("exec_rst_outputs", 32'({out_valid, out_result, out_c, out_z, out_n, out_v}), 32'd0);
        check("exec_rst_adder", 32'({add_a, add_b, add_cin}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_stale_result", 32'(out_valid), 32'd0);
        end
        runOp("adc_after_rst", 3'd1, 8'h00, 8'h00, 8'(CARRY_RESET), {1'b0, ~CARRY_RESET, 2'b00});

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_op     = 3'($urandom_range(0, 7));
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
